// File: rtl/tick_pkg.sv
// Shared types for the tick prescaler: FSM states and counting modes.
package tick_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_t;

endpackage

// File: rtl/tick_prescaler_if.sv
// Control/status bundle of one prescaler stage; master drives controls, slave is the stage.
interface tick_prescaler_if #(
  parameter int unsigned CNT_W = 8
);
  logic             tick_in;
  logic             enable;
  logic             mode;
  logic             start;
  logic             clear;
  logic             tc_load;
  logic [CNT_W-1:0] tc_in;
  logic             timeout;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] tc_cur;
  logic             busy;
  logic             done;

  modport master (
    output tick_in, enable, mode, start, clear, tc_load, tc_in,
    input  timeout, count, tc_cur, busy, done
  );

  modport slave (
    input  tick_in, enable, mode, start, clear, tc_load, tc_in,
    output timeout, count, tc_cur, busy, done
  );
endinterface

// File: rtl/tick_prescaler.sv
// Tick divider: counts input strobes and pulses timeout every tc_cur strobes,
// periodic or one-shot, with runtime terminal count and start/clear/pause.
module tick_prescaler
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DEFAULT_TC = 5
) (
  input logic               clk,
  input logic               rst,
  tick_prescaler_if.slave   bus
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] tc_last;

  // Last count value before wrap; only used when tc_q != 0, so no underflow.
  assign tc_last = tc_q - CNT_W'(1);

  // Next-state logic, priority clear > tc_load > start > tick.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    count_d   = count_q;
    tc_d      = tc_q;
    done_d    = done_q;
    timeout_d = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.tc_load) begin
      tc_d    = bus.tc_in;
      count_d = '0;
    end else if (bus.start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
      count_d = '0;
      mode_d  = mode_t'(bus.mode);
      done_d  = 1'b0;
    end else if ((state_q == ST_RUN) && bus.enable && bus.tick_in && (tc_q != '0)) begin
      if (count_q == tc_last) begin
        count_d   = '0;
        timeout_d = 1'b1;
        if (mode_q == MODE_ONESHOT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
    busy_d = (state_d == ST_RUN);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_PERIODIC;
      count_q   <= '0;
      tc_q      <= CNT_W'(DEFAULT_TC);
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.timeout = timeout_q;
  assign bus.count   = count_q;
  assign bus.tc_cur  = tc_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Directed self-checking bench for tick_prescaler.
module tb_tick_prescaler;

  localparam int unsigned CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  tick_prescaler_if #(.CNT_W(CNT_W)) bus ();

  tick_prescaler #(.CNT_W(CNT_W), .DEFAULT_TC(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
  endtask

  task automatic do_load(input logic [CNT_W-1:0] tc);
    bus.tc_in = tc; bus.tc_load = 1'b1; step(); bus.tc_load = 1'b0;
  endtask

  task automatic do_start(input logic m);
    bus.mode = m; bus.start = 1'b1; step(); bus.start = 1'b0;
  endtask

  initial begin
    int pulses;
    bus.tick_in = 1'b0; bus.enable = 1'b1; bus.mode = 1'b0;
    bus.start = 1'b0; bus.clear = 1'b0; bus.tc_load = 1'b0; bus.tc_in = '0;

    // Reset values
    rst = 1'b0; step(); step(); rst = 1'b1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_tc", 32'(bus.tc_cur), 5);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_timeout", 32'(bus.timeout), 0);

    // Periodic TC=5, 12 ticks spaced 3 clocks
    do_start(1'b0);
    check("p_busy_start", 32'(bus.busy), 1);
    for (int i = 1; i <= 12; i++) begin
      bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0;
      check($sformatf("p_to_%0d", i), 32'(bus.timeout), 32'((i % 5) == 0));
      check($sformatf("p_busy_%0d", i), 32'(bus.busy), 1);
      step();
      check($sformatf("p_to_low_%0d", i), 32'(bus.timeout), 0);
      step();
    end
    check("p_count12", 32'(bus.count), 2);

    // One-shot TC=3, 5 ticks
    do_clear();
    check("os_clear_busy", 32'(bus.busy), 0);
    do_load(8'd3);
    check("os_tc", 32'(bus.tc_cur), 3);
    do_start(1'b1);
    check("os_busy", 32'(bus.busy), 1);
    for (int i = 1; i <= 5; i++) begin
      bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0;
      check($sformatf("os_to_%0d", i), 32'(bus.timeout), 32'(i == 3));
      step();
    end
    check("os_done", 32'(bus.done), 1);
    check("os_busy_end", 32'(bus.busy), 0);
    check("os_count", 32'(bus.count), 0);
    do_start(1'b1);
    check("os_rearm_done", 32'(bus.done), 0);
    check("os_rearm_busy", 32'(bus.busy), 1);

    // Periodic TC=4, tick held high 12 cycles
    do_clear();
    do_load(8'd4);
    do_start(1'b0);
    pulses = 0;
    bus.tick_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.timeout) pulses++;
      check($sformatf("cont_to_%0d", i), 32'(bus.timeout), 32'((i % 4) == 0));
    end
    bus.tick_in = 1'b0;
    step();
    check("cont_to_after", 32'(bus.timeout), 0);
    check("cont_pulses", 32'(pulses), 3);

    // Pause: TC=5, 3 ticks, 4 paused ticks, 2 ticks; start with tick discards it
    do_clear();
    do_load(8'd5);
    bus.tick_in = 1'b1; bus.mode = 1'b0; bus.start = 1'b1; step();
    bus.start = 1'b0; bus.tick_in = 1'b0;
    check("start_tick_count", 32'(bus.count), 0);
    for (int i = 1; i <= 3; i++) begin
      bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0; step();
    end
    check("pause_pre", 32'(bus.count), 3);
    bus.enable = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0;
      check($sformatf("pause_cnt_%0d", i), 32'(bus.count), 3);
      check($sformatf("pause_to_%0d", i), 32'(bus.timeout), 0);
      step();
    end
    bus.enable = 1'b1;
    bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0;
    check("resume1_to", 32'(bus.timeout), 0);
    check("resume1_cnt", 32'(bus.count), 4);
    step();
    bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0;
    check("resume2_to", 32'(bus.timeout), 1);
    check("resume2_cnt", 32'(bus.count), 0);
    step();

    // TC=0 inhibits counting
    do_load(8'd0);
    check("tc0_tc", 32'(bus.tc_cur), 0);
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0;
      if (bus.timeout) pulses++;
      step();
    end
    check("tc0_pulses", 32'(pulses), 0);
    check("tc0_count", 32'(bus.count), 0);
    check("tc0_busy", 32'(bus.busy), 1);

    // Clear coincident with tick at count 4
    do_clear();
    do_load(8'd5);
    do_start(1'b0);
    for (int i = 1; i <= 4; i++) begin
      bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0; step();
    end
    check("clr_pre", 32'(bus.count), 4);
    bus.tick_in = 1'b1; bus.clear = 1'b1; step();
    bus.tick_in = 1'b0; bus.clear = 1'b0;
    check("clr_count", 32'(bus.count), 0);
    check("clr_busy", 32'(bus.busy), 0);
    check("clr_to", 32'(bus.timeout), 0);
    step();
    check("clr_to_next", 32'(bus.timeout), 0);

    // Reset sampled with the terminal tick cancels the pulse
    do_load(8'd3);
    do_start(1'b0);
    for (int i = 1; i <= 2; i++) begin
      bus.tick_in = 1'b1; step(); bus.tick_in = 1'b0; step();
    end
    bus.tick_in = 1'b1; rst = 1'b0; step();
    bus.tick_in = 1'b0; rst = 1'b1;
    check("rst_mid_to", 32'(bus.timeout), 0);
    check("rst_mid_tc", 32'(bus.tc_cur), 5);
    check("rst_mid_busy", 32'(bus.busy), 0);
    check("rst_mid_count", 32'(bus.count), 0);
    step();
    check("rst_mid_to_next", 32'(bus.timeout), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
